// File: rtl/lc3_mem_arbiter_pkg.sv
// Shared types and constants for the LC-3 memory-port arbiter.
package lc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef logic [15:0] lc3_word_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/lc3_mem_arbiter_if.sv
// Requester and memory-side signal bundle of the LC-3 memory arbiter.
interface lc3_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] memory_addr;
    logic [DATA_W-1:0] memory_din;
    logic              memWE;
    logic [DATA_W-1:0] memory_dout;
    logic              busy;
    logic              grant_id;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memory_dout,
        output ack0, ack1, rdata0, rdata1, memory_addr, memory_din, memWE, busy, grant_id
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memory_dout,
        input  ack0, ack1, rdata0, rdata1, memory_addr, memory_din, memWE, busy, grant_id
    );

endinterface

// File: rtl/lc3_mem_arbiter_rr_pick.sv
// Combinational two-way pick: a lone request wins outright, ties go to the port
// that did not win last time unless fixed priority favours the CPU port.
module lc3_rr_pick
    import lc3_mem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic fixed_pri,
    output logic valid,
    output logic winner
);

    // Select the winning port from the current request pair
    always_comb begin
        valid  = 1'b0;
        winner = PORT_CPU;
        case ({req1, req0})
            2'b01: begin
                valid  = 1'b1;
                winner = PORT_CPU;
            end
            2'b10: begin
                valid  = 1'b1;
                winner = PORT_DMA;
            end
            2'b11: begin
                valid = 1'b1;
                if (fixed_pri) begin
                    winner = PORT_CPU;
                end else begin
                    winner = ~last_grant;
                end
            end
            default: begin
                valid  = 1'b0;
                winner = PORT_CPU;
            end
        endcase
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single LC-3 memory port between the CPU (port 0) and the loader/DMA
// engine (port 1): one latched transaction at a time, fixed memory latency, one-cycle ack.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_LAT   = 2,
    parameter int FIXED_PRI = 0
) (
    input  logic             clk,
    input  logic             rst,
    lc3_mem_arbiter_if.slave bus
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $error("lc3_mem_arbiter: MEM_LAT must lie in 1..15");
        end
    endgenerate

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    arb_state_t        state_r;
    logic [3:0]        lat_cnt_r;
    logic              last_grant_r;
    logic              grant_id_r;
    logic              we_lat_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_din_r;
    logic              mem_we_r;
    logic              busy_r;
    logic              ack0_r;
    logic              ack1_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;

    logic              pick_valid_s;
    logic              pick_winner_s;

    lc3_rr_pick u_pick (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant_r),
        .fixed_pri  (FIXED_PRI != 0),
        .valid      (pick_valid_s),
        .winner     (pick_winner_s)
    );

    // Arbitration FSM, request latch, memory drive and completion outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            lat_cnt_r    <= 4'd0;
            last_grant_r <= PORT_DMA;
            grant_id_r   <= PORT_CPU;
            we_lat_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_din_r    <= '0;
            mem_we_r     <= 1'b0;
            busy_r       <= 1'b0;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            rdata0_r     <= '0;
            rdata1_r     <= '0;
        end else begin
            // Write strobe and acks are single-cycle pulses unless re-set below
            mem_we_r <= 1'b0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_valid_s) begin
                        last_grant_r <= pick_winner_s;
                        grant_id_r   <= pick_winner_s;
                        lat_cnt_r    <= LAT_LOAD;
                        busy_r       <= 1'b1;
                        state_r      <= ACCESS;
                        if (pick_winner_s == PORT_CPU) begin
                            we_lat_r   <= bus.we0;
                            mem_addr_r <= bus.addr0;
                            mem_din_r  <= bus.wdata0;
                            mem_we_r   <= bus.we0;
                        end else begin
                            we_lat_r   <= bus.we1;
                            mem_addr_r <= bus.addr1;
                            mem_din_r  <= bus.wdata1;
                            mem_we_r   <= bus.we1;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (lat_cnt_r == 4'd0) begin
                        state_r <= DONE;
                        if (grant_id_r == PORT_CPU) begin
                            ack0_r <= 1'b1;
                            if (!we_lat_r) begin
                                rdata0_r <= bus.memory_dout;
                            end else begin
                                rdata0_r <= rdata0_r;
                            end
                        end else begin
                            ack1_r <= 1'b1;
                            if (!we_lat_r) begin
                                rdata1_r <= bus.memory_dout;
                            end else begin
                                rdata1_r <= rdata1_r;
                            end
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.memory_addr = mem_addr_r;
    assign bus.memory_din  = mem_din_r;
    assign bus.memWE       = mem_we_r;
    assign bus.busy        = busy_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.ack0        = ack0_r;
    assign bus.ack1        = ack1_r;
    assign bus.rdata0      = rdata0_r;
    assign bus.rdata1      = rdata1_r;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: four configurations checked every cycle against a
// transaction-age model, plus directed scenarios with literal expectations.
module tb_lc3_mem_arbiter;

    localparam int N = 4;
    localparam int LAT_A [N] = '{2, 2, 1, 15};
    localparam int FP_A  [N] = '{0, 1, 0, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    logic        req0_v [N];
    logic        req1_v [N];
    logic        we0_v [N];
    logic        we1_v [N];
    logic [15:0] addr0_v [N];
    logic [15:0] addr1_v [N];
    logic [15:0] wdata0_v [N];
    logic [15:0] wdata1_v [N];
    logic [15:0] dout_v [N];
    logic        ack0_v [N];
    logic        ack1_v [N];
    logic        mwe_v [N];
    logic        busy_v [N];
    logic        gid_v [N];
    logic [15:0] rd0_v [N];
    logic [15:0] rd1_v [N];
    logic [15:0] maddr_v [N];
    logic [15:0] mdin_v [N];

    for (genvar g = 0; g < N; g++) begin : g_inst
        lc3_mem_arbiter_if bus ();
        lc3_mem_arbiter #(
            .ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT_A[g]), .FIXED_PRI(FP_A[g])
        ) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );
        assign bus.req0        = req0_v[g];
        assign bus.req1        = req1_v[g];
        assign bus.we0         = we0_v[g];
        assign bus.we1         = we1_v[g];
        assign bus.addr0       = addr0_v[g];
        assign bus.addr1       = addr1_v[g];
        assign bus.wdata0      = wdata0_v[g];
        assign bus.wdata1      = wdata1_v[g];
        assign bus.memory_dout = dout_v[g];
        assign ack0_v[g]       = bus.ack0;
        assign ack1_v[g]       = bus.ack1;
        assign mwe_v[g]        = bus.memWE;
        assign busy_v[g]       = bus.busy;
        assign gid_v[g]        = bus.grant_id;
        assign rd0_v[g]        = bus.rdata0;
        assign rd1_v[g]        = bus.rdata1;
        assign maddr_v[g]      = bus.memory_addr;
        assign mdin_v[g]       = bus.memory_din;
    end

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents are keyed by the top address nibble.
    logic [15:0] mem_dut [N][16];
    logic [15:0] mem_mod [N][16];

    function automatic logic [3:0] slot(input logic [15:0] a);
        return a[15:12];
    endfunction

    function automatic logic [15:0] b2w(input logic b);
        return {15'd0, b};
    endfunction

    // Memory seen by the DUT: writes on memWE, read data presented mid-cycle
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (mwe_v[i] === 1'b1) mem_dut[i][slot(maddr_v[i])] <= mdin_v[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) dout_v[i] <= mem_dut[i][slot(maddr_v[i])];
    end

    // Model: each transaction is tracked by its age in cycles since the grant edge.
    int          m_age [N];
    logic        m_act [N];
    logic        m_last [N];
    logic        m_gid [N];
    logic        m_we [N];
    logic [15:0] m_addr [N];
    logic [15:0] m_din [N];
    logic [15:0] m_rd0 [N];
    logic [15:0] m_rd1 [N];

    function automatic logic win(input int i);
        if (req0_v[i] && req1_v[i]) return (FP_A[i] != 0) ? 1'b0 : ~m_last[i];
        return req1_v[i];
    endfunction

    always @(posedge clk or posedge rst) begin : model
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_act[i]  <= 1'b0;  m_age[i]  <= 0;      m_last[i] <= 1'b1;
                m_gid[i]  <= 1'b0;  m_we[i]   <= 1'b0;   m_addr[i] <= 16'h0000;
                m_din[i]  <= 16'h0000; m_rd0[i] <= 16'h0000; m_rd1[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_act[i]) begin
                    m_age[i] <= m_age[i] + 1;
                    if (m_age[i] + 1 == LAT_A[i] && !m_we[i]) begin
                        if (m_gid[i]) m_rd1[i] <= mem_mod[i][slot(m_addr[i])];
                        else          m_rd0[i] <= mem_mod[i][slot(m_addr[i])];
                    end
                    if (m_age[i] == LAT_A[i]) m_act[i] <= 1'b0;
                end else if (req0_v[i] || req1_v[i]) begin
                    m_act[i]  <= 1'b1;
                    m_age[i]  <= 0;
                    m_gid[i]  <= win(i);
                    m_last[i] <= win(i);
                    m_we[i]   <= win(i) ? we1_v[i] : we0_v[i];
                    m_addr[i] <= win(i) ? addr1_v[i] : addr0_v[i];
                    m_din[i]  <= win(i) ? wdata1_v[i] : wdata0_v[i];
                    if (win(i) ? we1_v[i] : we0_v[i])
                        mem_mod[i][slot(win(i) ? addr1_v[i] : addr0_v[i])] <= win(i) ? wdata1_v[i] : wdata0_v[i];
                end
            end
        end
    end

    task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst%0d @cyc %0d: got %h expected %h", name, i, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    int          ack_cnt0 [N];
    int          ack_cnt1 [N];
    int          we_cnt [N];
    logic [15:0] wr_addr [N];
    logic [15:0] wr_din [N];

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin : compare
        if (cyc > 0) begin
            for (int i = 0; i < N; i++) begin
                chk("ack0", i, b2w(ack0_v[i]), b2w(m_act[i] && m_age[i] == LAT_A[i] && !m_gid[i]));
                chk("ack1", i, b2w(ack1_v[i]), b2w(m_act[i] && m_age[i] == LAT_A[i] && m_gid[i]));
                chk("memWE", i, b2w(mwe_v[i]), b2w(m_act[i] && m_age[i] == 0 && m_we[i]));
                chk("busy", i, b2w(busy_v[i]), b2w(m_act[i]));
                chk("grant_id", i, b2w(gid_v[i]), b2w(m_gid[i]));
                chk("memory_addr", i, maddr_v[i], m_addr[i]);
                chk("memory_din", i, mdin_v[i], m_din[i]);
                chk("rdata0", i, rd0_v[i], m_rd0[i]);
                chk("rdata1", i, rd1_v[i], m_rd1[i]);
                if (ack0_v[i] === 1'b1) ack_cnt0[i] <= ack_cnt0[i] + 1;
                if (ack1_v[i] === 1'b1) ack_cnt1[i] <= ack_cnt1[i] + 1;
                if (mwe_v[i] === 1'b1) begin
                    we_cnt[i]  <= we_cnt[i] + 1;
                    wr_addr[i] <= maddr_v[i];
                    wr_din[i]  <= mdin_v[i];
                end
            end
        end
    end

    task automatic xact(input int i, input logic p, input logic we, input logic [15:0] a,
                        input logic [15:0] d, output int lat, output logic [15:0] rd);
        int t0;
        bit got;
        @(negedge clk);
        if (p) begin
            we1_v[i] = we; addr1_v[i] = a; wdata1_v[i] = d; req1_v[i] = 1'b1;
        end else begin
            we0_v[i] = we; addr0_v[i] = a; wdata0_v[i] = d; req0_v[i] = 1'b1;
        end
        t0 = cyc; got = 1'b0; lat = -1; rd = 16'h0000;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if ((p ? ack1_v[i] : ack0_v[i]) === 1'b1) begin
                got = 1'b1;
                lat = cyc - t0;
                rd  = p ? rd1_v[i] : rd0_v[i];
            end
        end
        if (p) req1_v[i] = 1'b0; else req0_v[i] = 1'b0;
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL xact_timeout inst%0d port%0d: got no ack expected ack within 40 cycles", i, p);
        end
    endtask

    int ord_q [$];
    int tim_q [$];

    task automatic pair(input int i);
        int nack;
        nack = 0;
        ord_q.delete();
        tim_q.delete();
        @(negedge clk);
        we0_v[i] = 1'b0; addr0_v[i] = 16'h5000; wdata0_v[i] = 16'h0000; req0_v[i] = 1'b1;
        we1_v[i] = 1'b0; addr1_v[i] = 16'h6000; wdata1_v[i] = 16'h0000; req1_v[i] = 1'b1;
        for (int k = 0; k < 100 && nack < 6; k++) begin
            @(negedge clk);
            if (ack0_v[i] === 1'b1) begin ord_q.push_back(0); tim_q.push_back(cyc); nack++; end
            if (ack1_v[i] === 1'b1) begin ord_q.push_back(1); tim_q.push_back(cyc); nack++; end
        end
        req0_v[i] = 1'b0;
        req1_v[i] = 1'b0;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got no end of test expected finish before 50000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int          lat;
        int          snap;
        logic [15:0] rd;
        for (int i = 0; i < N; i++) begin
            req0_v[i] = 1'b0; req1_v[i] = 1'b0; we0_v[i] = 1'b0; we1_v[i] = 1'b0;
            addr0_v[i] = 16'h0000; addr1_v[i] = 16'h0000;
            wdata0_v[i] = 16'h0000; wdata1_v[i] = 16'h0000; dout_v[i] = 16'h0000;
            ack_cnt0[i] = 0; ack_cnt1[i] = 0; we_cnt[i] = 0;
            wr_addr[i] = 16'h0000; wr_din[i] = 16'h0000;
            for (int k = 0; k < 16; k++) begin
                mem_dut[i][k] = {4'(k), 12'hA5A};
                mem_mod[i][k] = {4'(k), 12'hA5A};
            end
            mem_dut[i][3] = 16'h1234;
            mem_mod[i][3] = 16'h1234;
        end

        repeat (2) @(negedge clk);
        chk("reset_busy", 0, b2w(busy_v[0]), 16'h0000);
        chk("reset_memWE", 0, b2w(mwe_v[0]), 16'h0000);
        chk("reset_addr", 0, maddr_v[0], 16'h0000);
        rst = 1'b0;

        // Single CPU read: grant edge then ack MEM_LAT edges later
        xact(0, 1'b0, 1'b0, 16'h3000, 16'h0000, lat, rd);
        chk_int("t1_latency", lat, 3);
        chk("t1_rdata0", 0, rd, 16'h1234);
        @(negedge clk);
        chk_int("t1_no_ack1", ack_cnt1[0], 0);

        // DMA write then CPU read-back
        snap = we_cnt[0];
        xact(0, 1'b1, 1'b1, 16'h4000, 16'hBEEF, lat, rd);
        @(negedge clk);
        chk_int("t2_we_cycles", we_cnt[0] - snap, 1);
        chk("t2_wr_addr", 0, wr_addr[0], 16'h4000);
        chk("t2_wr_din", 0, wr_din[0], 16'hBEEF);
        xact(0, 1'b0, 1'b0, 16'h4000, 16'h0000, lat, rd);
        chk("t2_readback", 0, rd, 16'hBEEF);

        // Reset in the first ACCESS cycle of a DMA write
        snap = ack_cnt1[0];
        @(negedge clk);
        we1_v[0] = 1'b1; addr1_v[0] = 16'h7000; wdata1_v[0] = 16'hCAFE; req1_v[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_memWE_before", 0, b2w(mwe_v[0]), 16'h0001);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_memWE_in_rst", 0, b2w(mwe_v[0]), 16'h0000);
        chk("t5_busy_in_rst", 0, b2w(busy_v[0]), 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_int("t5_no_ack", ack_cnt1[0], snap);
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            @(negedge clk);
            if (ack1_v[0] === 1'b1) begin
                lat = k;
                chk("t5_grant_id", 0, b2w(gid_v[0]), 16'h0001);
            end
        end
        req1_v[0] = 1'b0;
        if (lat < 0) chk_int("t5_ack_timeout", lat, 3);

        // Both ports held, round-robin
        pair(0);
        chk_int("t3_acks", ord_q.size(), 6);
        for (int k = 0; k < ord_q.size(); k++) begin
            chk_int("t3_order", ord_q[k], k % 2);
            if (k > 0) chk_int("t3_spacing", tim_q[k] - tim_q[k - 1], 4);
        end
        chk("t3_rdata0", 0, rd0_v[0], 16'h5A5A);
        chk("t3_rdata1", 0, rd1_v[0], 16'h6A5A);

        // Both ports held, fixed priority
        pair(1);
        chk_int("t4_acks", ord_q.size(), 6);
        for (int k = 0; k < ord_q.size(); k++) begin
            chk_int("t4_order", ord_q[k], 0);
            if (k > 0) chk_int("t4_spacing", tim_q[k] - tim_q[k - 1], 4);
        end
        repeat (3) @(negedge clk);
        chk_int("t4_no_ack1", ack_cnt1[1], 0);

        // Latency extremes
        xact(2, 1'b0, 1'b0, 16'h3000, 16'h0000, lat, rd);
        chk_int("t6_lat1", lat, 2);
        chk("t6_lat1_rdata", 2, rd, 16'h1234);
        xact(3, 1'b1, 1'b0, 16'h3000, 16'h0000, lat, rd);
        chk_int("t6_lat15", lat, 16);
        chk("t6_lat15_rdata", 3, rd, 16'h1234);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
